// File: rtl/vga_rect_fill.sv
// vga_rect_fill - solid rectangle filler for a linear video memory.
//
// Accepts a rectangle command (top-left iX/iY, size iW/iH, colour iColor)
// while idle and then issues one video-memory write per clock in row-major
// order. The write address is FB_WIDTH*row + col, wrapping modulo 2^ADDR_W.
// A one-cycle oDone pulse follows the last write. iAbort cancels a fill
// without oDone.
//
// Optional feature: define VGA_RECT_CLIP_EN to clip the rectangle to the
// FB_WIDTH x FB_HEIGHT framebuffer at acceptance. When it is undefined,
// every iW*iH pixel is written.
//
// Ports
//   Clock         in   rising-edge clock
//   Reset         in   asynchronous active-low reset
//   iStart        in   command strobe, sampled only while oReady=1
//   iAbort        in   cancel an active fill
//   iX, iY        in   top-left column / row (16 bit)
//   iW, iH        in   width / height in pixels (16 bit)
//   iColor        in   fill colour
//   oReady        out  idle; a command is accepted this cycle if iStart=1
//   oBusy         out  fill in progress
//   oDone         out  one-cycle completion pulse
//   oWriteEnable  out  video-memory write strobe
//   oWriteAddress out  video-memory write address
//   oDataOut      out  video-memory write data
module vga_rect_fill #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_W    = 19,
  parameter int COLOR_W   = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iAbort,
  input  logic [15:0]        iX,
  input  logic [15:0]        iY,
  input  logic [15:0]        iW,
  input  logic [15:0]        iH,
  input  logic [COLOR_W-1:0] iColor,
  output logic               oReady,
  output logic               oBusy,
  output logic               oDone,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [COLOR_W-1:0] oDataOut
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

  state_t              r_state, w_state_next;
  logic [15:0]         r_col, w_col_next;
  logic [15:0]         r_row, w_row_next;
  logic [15:0]         r_w, w_w_next;
  logic [15:0]         r_h, w_h_next;
  logic [ADDR_W-1:0]   r_base, w_base_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [COLOR_W-1:0]  r_color, w_color_next;
  logic                r_ready, w_ready_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;
  logic                r_we, w_we_next;

  logic [15:0]         w_eff_w, w_eff_h;
  logic [ADDR_W-1:0]   w_start_addr;
  logic                w_last_col, w_last_row;

  // Effective rectangle size at acceptance.
`ifdef VGA_RECT_CLIP_EN
  logic [31:0] w_room_x, w_room_y;
  always_comb begin
    w_room_x = 32'(FB_WIDTH)  - 32'(iX);
    w_room_y = 32'(FB_HEIGHT) - 32'(iY);
    w_eff_w  = iW;
    w_eff_h  = iH;
    if (32'(iX) >= 32'(FB_WIDTH))   w_eff_w = 16'd0;
    else if (32'(iW) > w_room_x)    w_eff_w = w_room_x[15:0];
    if (32'(iY) >= 32'(FB_HEIGHT))  w_eff_h = 16'd0;
    else if (32'(iH) > w_room_y)    w_eff_h = w_room_y[15:0];
  end
`else
  assign w_eff_w = iW;
  assign w_eff_h = iH;
`endif

  // The only multiply: start address, evaluated once per accepted command.
  assign w_start_addr = ADDR_W'(iY) * ROW_STEP + ADDR_W'(iX);

  assign w_last_col = (r_col == r_w - 16'd1);
  assign w_last_row = (r_row == r_h - 16'd1);

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_w_next     = r_w;
    w_h_next     = r_h;
    w_base_next  = r_base;
    w_addr_next  = r_addr;
    w_color_next = r_color;
    w_ready_next = r_ready;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_we_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        // iAbort is meaningless here, so start wins when both are high.
        if (iStart) begin
          w_w_next     = w_eff_w;
          w_h_next     = w_eff_h;
          w_col_next   = 16'd0;
          w_row_next   = 16'd0;
          w_base_next  = w_start_addr;
          w_addr_next  = w_start_addr;
          w_color_next = iColor;
          w_ready_next = 1'b0;
          if (w_eff_w == 16'd0 || w_eff_h == 16'd0) begin
            w_state_next = S_DONE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_FILL;
            w_busy_next  = 1'b1;
            w_we_next    = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (iAbort) begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
          w_ready_next = 1'b1;
        end else if (w_last_col && w_last_row) begin
          w_state_next = S_DONE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end else if (w_last_col) begin
          // Next row: advance the running row base instead of multiplying.
          w_col_next  = 16'd0;
          w_row_next  = r_row + 16'd1;
          w_base_next = r_base + ROW_STEP;
          w_addr_next = r_base + ROW_STEP;
          w_we_next   = 1'b1;
        end else begin
          w_col_next  = r_col + 16'd1;
          w_addr_next = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          w_we_next   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_ready_next = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
        w_ready_next = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_base  <= '0;
      r_addr  <= '0;
      r_color <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_w     <= w_w_next;
      r_h     <= w_h_next;
      r_base  <= w_base_next;
      r_addr  <= w_addr_next;
      r_color <= w_color_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_we    <= w_we_next;
    end
  end

  assign oReady        = r_ready;
  assign oBusy         = r_busy;
  assign oDone         = r_done;
  assign oWriteEnable  = r_we;
  assign oWriteAddress = r_addr;
  assign oDataOut      = r_color;

endmodule

// File: tb/tb_vga_rect_fill.sv
module tb_vga_rect_fill;
  localparam int FBW = 400;
  localparam int FBH = 240;
  localparam int AW  = 19;
  localparam int CW  = 3;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   x = '0, y = '0, w = '0, h = '0;
  logic [CW-1:0] color = '0;
  logic          ready, busy, done, we;
  logic [AW-1:0] addr;
  logic [CW-1:0] data;

  always #5 clk = ~clk;

  vga_rect_fill #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .ADDR_W(AW), .COLOR_W(CW)) dut (
    .Clock(clk), .Reset(rst_n), .iStart(start), .iAbort(abort),
    .iX(x), .iY(y), .iW(w), .iH(h), .iColor(color),
    .oReady(ready), .oBusy(busy), .oDone(done), .oWriteEnable(we),
    .oWriteAddress(addr), .oDataOut(data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-command observations.
  int unsigned   wr_addr[$];
  logic [CW-1:0] wr_data[$];
  int done_k, ready_k, last_wr_k, first_wr_k;
  int k0_busy, k0_ready, ready_after;
  bit timed_out;

  // act_kind: 0 none, 1 second iStart at write act_at, 2 reset at write act_at,
  //           3 iAbort at write act_at, 4 iAbort together with iStart.
  task automatic run_cmd(input int cx, input int cy, input int cw, input int ch,
                         input int cc, input int act_at, input int act_kind);
    int t;
    bit ended;
    wr_addr.delete(); wr_data.delete();
    done_k = -1; ready_k = -1; last_wr_k = -1; first_wr_k = -1;
    ready_after = 0; timed_out = 1'b0; ended = 1'b0;
    t = 0;
    while (!ready && t < 50) begin step(); t++; end
    x = 16'(cx); y = 16'(cy); w = 16'(cw); h = 16'(ch); color = CW'(cc);
    start = 1'b1;
    abort = (act_kind == 4);
    step();
    start = 1'b0; abort = 1'b0;
    k0_busy = int'(busy); k0_ready = int'(ready);
    for (int k = 0; k < BUDGET; k++) begin
      if (k > 0) begin step(); start = 1'b0; abort = 1'b0; end
      if (we) begin
        wr_addr.push_back(int'(addr)); wr_data.push_back(data);
        if (first_wr_k < 0) first_wr_k = k;
        last_wr_k = k;
        if (wr_addr.size() == act_at) begin
          case (act_kind)
            1: begin start = 1'b1; x = 0; y = 0; w = 1; h = 1; color = 3'b111; end
            2: begin
              rst_n = 1'b0;
              #1;
              chk("rst_async_we", 32'(we), 0);
              chk("rst_async_ready", 32'(ready), 1);
              chk("rst_async_addr", 32'(addr), 0);
            end
            3: abort = 1'b1;
            default: ;
          endcase
        end
      end
      if (done) begin done_k = k; ended = 1'b1; break; end
      if (ready) begin ready_k = k; ended = 1'b1; break; end
    end
    if (!ended) begin timed_out = 1'b1; chk("cmd_timeout", 0, 1); end
    if (!rst_n) begin
      step();
      chk("rst_hold_we", 32'(we), 0);
      rst_n = 1'b1;
    end
    for (int p = 0; p < 4; p++) begin
      step();
      if (p == 0) ready_after = int'(ready);
      if (we) begin wr_addr.push_back(int'(addr)); wr_data.push_back(data); end
    end
  endtask

  function automatic int eff_w(int xx, int ww);
`ifdef VGA_RECT_CLIP_EN
    if (xx >= FBW) return 0;
    return (ww < FBW - xx) ? ww : FBW - xx;
`else
    return ww;
`endif
  endfunction

  function automatic int eff_h(int yy, int hh);
`ifdef VGA_RECT_CLIP_EN
    if (yy >= FBH) return 0;
    return (hh < FBH - yy) ? hh : FBH - yy;
`else
    return hh;
`endif
  endfunction

  typedef struct {
    int x, y, w, h, color;
    int n, first, last;
  } vec_t;

  vec_t vt[9];
  int   exp34[6];

  initial begin
    // Hand-computed vectors: {x, y, w, h, colour, writes, first addr, last addr}
    vt[0] = '{10, 2, 3, 2, 4, 6, 810, 1212};
    vt[1] = '{0, 0, 1, 1, 7, 1, 0, 0};
    vt[2] = '{0, 5, 0, 5, 2, 0, 0, 0};
    vt[3] = '{5, 0, 4, 0, 1, 0, 0, 0};
    vt[6] = '{100, 50, 4, 3, 5, 12, 20100, 20903};
`ifdef VGA_RECT_CLIP_EN
    vt[4] = '{399, 0, 2, 2, 1, 2, 399, 799};
    vt[5] = '{398, 239, 5, 3, 2, 2, 95998, 95999};
    vt[7] = '{400, 0, 3, 3, 6, 0, 0, 0};
    vt[8] = '{287, 1310, 2, 1, 3, 0, 0, 0};
`else
    vt[4] = '{399, 0, 2, 2, 1, 4, 399, 800};
    vt[5] = '{398, 239, 5, 3, 2, 15, 95998, 96802};
    vt[7] = '{400, 0, 3, 3, 6, 9, 400, 1202};
    vt[8] = '{287, 1310, 2, 1, 3, 2, 524287, 0};
`endif
    exp34 = '{810, 811, 812, 1210, 1211, 1212};

    // Reset state.
    step();
    chk("reset_ready", 32'(ready), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_we", 32'(we), 0);
    chk("reset_addr", 32'(addr), 0);
    chk("reset_data", 32'(data), 0);
    rst_n = 1'b1;
    step();
    chk("post_release_we", 32'(we), 0);
    chk("post_release_ready", 32'(ready), 1);

    // iAbort while idle changes nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_ready", 32'(ready), 1);
    chk("idle_abort_we", 32'(we), 0);

    // Table-driven commands.
    for (int i = 0; i < 9; i++) begin
      int ew, eh;
      ew = eff_w(vt[i].x, vt[i].w);
      eh = eff_h(vt[i].y, vt[i].h);
      run_cmd(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].color, 0, 0);
      $display("vec %0d: x=%0d y=%0d w=%0d h=%0d writes=%0d done_k=%0d",
               i, vt[i].x, vt[i].y, vt[i].w, vt[i].h, wr_addr.size(), done_k);
      chk($sformatf("v%0d_count", i), 32'(wr_addr.size()), 32'(vt[i].n));
      chk($sformatf("v%0d_k0_ready", i), 32'(k0_ready), 0);
      chk($sformatf("v%0d_k0_busy", i), 32'(k0_busy), (vt[i].n > 0) ? 1 : 0);
      chk($sformatf("v%0d_ready_after_done", i), 32'(ready_after), 1);
      if (vt[i].n > 0) begin
        chk($sformatf("v%0d_first", i), wr_addr[0], 32'(vt[i].first));
        chk($sformatf("v%0d_last", i), wr_addr[wr_addr.size()-1], 32'(vt[i].last));
        chk($sformatf("v%0d_first_k", i), 32'(first_wr_k), 0);
        chk($sformatf("v%0d_done_k", i), 32'(done_k), 32'(vt[i].n));
        for (int j = 0; j < wr_addr.size() && j < ew * eh; j++) begin
          int unsigned ea;
          ea = ((vt[i].y + j / ew) * FBW + vt[i].x + j % ew) % (1 << AW);
          chk($sformatf("v%0d_addr%0d", i, j), wr_addr[j], ea);
          chk($sformatf("v%0d_data%0d", i, j), 32'(wr_data[j]), 32'(vt[i].color));
        end
      end else begin
        chk($sformatf("v%0d_done_k", i), 32'(done_k), 0);
      end
    end

    // Second iStart during the 2nd write is ignored.
    run_cmd(10, 2, 3, 2, 4, 2, 1);
    $display("seq restart: writes=%0d done_k=%0d", wr_addr.size(), done_k);
    chk("restart_count", 32'(wr_addr.size()), 6);
    chk("restart_done_k", 32'(done_k), 6);
    for (int j = 0; j < 6 && j < wr_addr.size(); j++) begin
      chk($sformatf("restart_addr%0d", j), wr_addr[j], 32'(exp34[j]));
      chk($sformatf("restart_data%0d", j), 32'(wr_data[j]), 4);
    end

    // Reset during the 3rd write: nothing further after release.
    run_cmd(10, 2, 3, 2, 4, 3, 2);
    $display("seq reset: writes=%0d done_k=%0d", wr_addr.size(), done_k);
    chk("reset_mid_count", 32'(wr_addr.size()), 3);
    chk("reset_mid_no_done", 32'(done_k), 32'(-1));
    chk("reset_mid_data_cleared", 32'(data), 0);

    // Abort during the 4th write.
    run_cmd(10, 2, 3, 2, 4, 4, 3);
    $display("seq abort: writes=%0d done_k=%0d ready_k=%0d", wr_addr.size(), done_k, ready_k);
    chk("abort_count", 32'(wr_addr.size()), 4);
    chk("abort_no_done", 32'(done_k), 32'(-1));
    chk("abort_ready_k", 32'(ready_k), 4);

    // iStart and iAbort together while idle: command accepted and completes.
    run_cmd(0, 0, 2, 1, 6, 0, 4);
    $display("seq start+abort: writes=%0d done_k=%0d", wr_addr.size(), done_k);
    chk("start_abort_count", 32'(wr_addr.size()), 2);
    chk("start_abort_done_k", 32'(done_k), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_rect_fill.md
VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 400, framebuffer pixels per row.
REQ-002 SHALL have parameter FB_HEIGHT, default 240, framebuffer rows.
REQ-003 SHALL have parameter ADDR_W, default 19, video-memory write-address width.
REQ-004 SHALL have parameter COLOR_W, default 3, pixel colour width ({R,G,B}).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Clock  input  1  rising-edge system clock.
REQ-007 Reset  input  1  asynchronous active-low reset.
REQ-008 iStart  input  1  command strobe, sampled only while oReady=1.
REQ-009 iAbort  input  1  terminates an active fill.
REQ-010 iX, iY  input  16 each  top-left pixel column/row.
REQ-011 iW, iH  input  16 each  rectangle width/height in pixels.
REQ-012 iColor  input  COLOR_W  fill colour.
REQ-013 oReady  output  1  idle, command accepted this cycle if iStart=1.
REQ-014 oBusy  output  1  fill in progress.
REQ-015 oDone  output  1  one-cycle completion pulse.
REQ-016 oWriteEnable  output  1  video-memory write strobe.
REQ-017 oWriteAddress  output  ADDR_W  write address = FB_WIDTH*row + col.
REQ-018 oDataOut  output  COLOR_W  write data.

Function
REQ-019 States SHALL be IDLE, FILL, DONE; all outputs registered.
REQ-020 IDLE: oReady=1, oBusy=0, oWriteEnable=0; iStart=1 latches iX,iY,iW,iH,iColor and moves to FILL, or to DONE if effective W or H is 0.
REQ-021 FILL: oBusy=1, oReady=0; one write per cycle, first write in cycle after acceptance, row-major order (col increments, then row).
REQ-022 Row base SHALL be computed incrementally (base += FB_WIDTH per row); no multiplier in the datapath except at acceptance.
REQ-023 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-024 After the W*H-th write, FSM SHALL enter DONE: oDone=1 for exactly one cycle, oWriteEnable=0, then IDLE.
REQ-025 iStart during FILL or DONE SHALL be ignored; latched parameters SHALL NOT change.
REQ-026 iAbort=1 in FILL SHALL force oWriteEnable=0 next cycle and return to IDLE without oDone; iAbort in IDLE ignored.
REQ-027 Simultaneous iStart and iAbort in IDLE SHALL accept the command.
REQ-028 oDataOut SHALL hold the latched colour throughout FILL.

Reset
REQ-029 Reset low SHALL immediately force IDLE, oReady=1, oBusy=0, oDone=0, oWriteEnable=0, oWriteAddress=0, oDataOut=0, including mid-fill.
REQ-030 No write SHALL occur in the first cycle after Reset release unless a command was accepted in that cycle.

Configuration
REQ-031 Macro VGA_RECT_CLIP_EN SHALL control clipping.
REQ-032 Defined: at acceptance effective W=min(iW,FB_WIDTH-iX), H=min(iH,FB_HEIGHT-iY); iX>=FB_WIDTH or iY>=FB_HEIGHT gives zero area.
REQ-033 Undefined: no clipping; all iW*iH writes issued, addresses per REQ-017/REQ-023.

Verification
REQ-034 x=10,y=2,w=3,h=2,color=3'b100 -> 6 writes at 810,811,812,1210,1211,1212, data 3'b100; oDone the cycle after the last write.
REQ-035 w=0,h=5 -> no write; IDLE->DONE; oDone one cycle after acceptance; oReady high the following cycle.
REQ-036 Second iStart (x=0,y=0,w=1,h=1) during the 2nd write of REQ-034 -> ignored; only the 6 original addresses written.
REQ-037 Reset low during the 3rd write of REQ-034 -> oWriteEnable=0 and oReady=1 the same cycle; no further writes after release.
REQ-038 x=398,y=239,w=5,h=3: VGA_RECT_CLIP_EN defined -> writes 95998,95999 only; undefined -> 15 writes 95998-96002, 96398-96402, 96798-96802.
REQ-039 iAbort during the 4th write of REQ-034 -> 4 writes total, no oDone, oReady=1 the next cycle.
